ddram_arbiter: RTL and testbench

Two-port arbiter that shares the single DDRAM Avalon-MM master interface of `emu` between a high-priority video fetch port (A) and a low-priority loader/CPU port (B). It grants one port at a time, holds the grant for a whole read or write burst, and steers read data-valid strobes back to the owning port. It sits between the core's memory clients and the `DDRAM_*` top-level ports, replacing the constant tie-off.

---
 rtl/ddram_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_ddram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_arbiter.sv
// ddram_arbiter: shares the single DDRAM Avalon-MM master between a
// high-priority video fetch port (A) and a low-priority loader/CPU port (B).
// One port owns the DDRAM for a whole read or write burst. Read strobes are
// steered to the owning port only.
// Optional feature macro: DDRAM_ARB_FAIRNESS_EN (starvation guard for port B).
//
// Handshake: a port raises rd or we with addr/burstcnt/din/be stable and holds
// them while x_busy=1. A command or write beat is accepted on the rising edge
// where the request is high and x_busy=0. x_dout_ready qualifies x_dout for
// one cycle per read beat.
module ddram_arbiter #(
    parameter int MAX_WAIT = 64
) (
    input  logic        clk_sys,
    input  logic        reset_n,

    input  logic [28:0] a_addr,
    input  logic [7:0]  a_burstcnt,
    input  logic        a_rd,
    input  logic        a_we,
    input  logic [63:0] a_din,
    input  logic [7:0]  a_be,
    output logic        a_busy,
    output logic [63:0] a_dout,
    output logic        a_dout_ready,

    input  logic [28:0] b_addr,
    input  logic [7:0]  b_burstcnt,
    input  logic        b_rd,
    input  logic        b_we,
    input  logic [63:0] b_din,
    input  logic [7:0]  b_be,
    output logic        b_busy,
    output logic [63:0] b_dout,
    output logic        b_dout_ready,

    output logic        DDRAM_CLK,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,

    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_DATA, S_WR_DATA} state_t;
    typedef enum logic [1:0] {G_NONE, G_A, G_B} grant_t;

    state_t      state;
    grant_t      grant;
    logic [7:0]  beats;
    logic [28:0] hold_addr;
    logic [7:0]  hold_bc;

    logic        a_req, b_req, pick_b, starve;
    logic        sel_rd, sel_we;
    logic [28:0] sel_addr;
    logic [7:0]  sel_bc;
    logic [63:0] sel_din;
    logic [7:0]  sel_be;
    logic        owner_active;

    assign a_req     = a_rd | a_we;
    assign b_req     = b_rd | b_we;
    // B wins only when it is the sole requester or has waited too long.
    assign pick_b    = b_req & (~a_req | starve);
    assign dbg_state = state;
    assign DDRAM_CLK = clk_sys;

`ifdef DDRAM_ARB_FAIRNESS_EN
    localparam logic [7:0] MAX_WAIT_Q = 8'(MAX_WAIT);
    logic [7:0] wait_cnt;

    // Saturating count of cycles B has been pending without owning the bus.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
        end else if (state == S_IDLE && pick_b) begin
            wait_cnt <= 8'd0;
        end else if (b_req && grant != G_B && wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign starve = (wait_cnt >= MAX_WAIT_Q);
`else
    // Strict priority: MAX_WAIT is always 1..255, so this stays low.
    assign starve = (MAX_WAIT == 0);
`endif

    // Select the granted port's request signals; zero when nobody owns the bus.
    always_comb begin
        sel_rd   = 1'b0;
        sel_we   = 1'b0;
        sel_addr = 29'd0;
        sel_bc   = 8'd0;
        sel_din  = 64'd0;
        sel_be   = 8'd0;
        if (grant == G_A) begin
            sel_rd   = a_rd;
            sel_we   = a_we;
            sel_addr = a_addr;
            sel_bc   = a_burstcnt;
            sel_din  = a_din;
            sel_be   = a_be;
        end else if (grant == G_B) begin
            sel_rd   = b_rd;
            sel_we   = b_we;
            sel_addr = b_addr;
            sel_bc   = b_burstcnt;
            sel_din  = b_din;
            sel_be   = b_be;
        end
    end

    // Drive the DDRAM command port; data beats reuse the first beat's address.
    always_comb begin
        DDRAM_RD       = 1'b0;
        DDRAM_WE       = 1'b0;
        DDRAM_ADDR     = 29'd0;
        DDRAM_BURSTCNT = 8'd0;
        DDRAM_DIN      = 64'd0;
        DDRAM_BE       = 8'd0;
        case (state)
            S_ISSUE: begin
                DDRAM_RD       = sel_rd;
                DDRAM_WE       = sel_we;
                DDRAM_ADDR     = sel_addr;
                DDRAM_BURSTCNT = sel_bc;
                DDRAM_DIN      = sel_din;
                DDRAM_BE       = sel_be;
            end
            S_RD_DATA: begin
                DDRAM_ADDR     = hold_addr;
                DDRAM_BURSTCNT = hold_bc;
            end
            S_WR_DATA: begin
                DDRAM_WE       = sel_we;
                DDRAM_ADDR     = hold_addr;
                DDRAM_BURSTCNT = hold_bc;
                DDRAM_DIN      = sel_din;
                DDRAM_BE       = sel_be;
            end
            default: ;
        endcase
    end

    assign owner_active = (state == S_ISSUE) || (state == S_WR_DATA);
    assign a_busy       = ~(grant == G_A && owner_active) | DDRAM_BUSY;
    assign b_busy       = ~(grant == G_B && owner_active) | DDRAM_BUSY;
    assign a_dout       = DDRAM_DOUT;
    assign b_dout       = DDRAM_DOUT;
    assign a_dout_ready = DDRAM_DOUT_READY && state == S_RD_DATA && grant == G_A;
    assign b_dout_ready = DDRAM_DOUT_READY && state == S_RD_DATA && grant == G_B;

    // Arbitration and burst tracking FSM.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            grant     <= G_NONE;
            beats     <= 8'd0;
            hold_addr <= 29'd0;
            hold_bc   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (a_req || b_req) begin
                        grant <= pick_b ? G_B : G_A;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A dropped request here is a client protocol error; wait.
                    if ((sel_rd || sel_we) && !DDRAM_BUSY) begin
                        hold_addr <= sel_addr;
                        hold_bc   <= sel_bc;
                        if (sel_rd) begin
                            beats <= (sel_bc == 8'd0) ? 8'd1 : sel_bc;
                            state <= S_RD_DATA;
                        end else if (sel_bc <= 8'd1) begin
                            state <= S_IDLE;
                            grant <= G_NONE;
                        end else begin
                            beats <= sel_bc - 8'd1;
                            state <= S_WR_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (DDRAM_DOUT_READY) begin
                        beats <= beats - 8'd1;
                        if (beats == 8'd1) begin
                            state <= S_IDLE;
                            grant <= G_NONE;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (sel_we && !DDRAM_BUSY) begin
                        beats <= beats - 8'd1;
                        if (beats == 8'd1) begin
                            state <= S_IDLE;
                            grant <= G_NONE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= G_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Directed bench for ddram_arbiter: A read burst, stalled B write burst,
// simultaneous requests, starvation behaviour, reset mid-burst, zero burstcnt.
module tb_ddram_arbiter;

    localparam int W = 72;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;

    logic [28:0] a_addr = '0, b_addr = '0;
    logic [7:0]  a_burstcnt = '0, b_burstcnt = '0;
    logic        a_rd = 1'b0, a_we = 1'b0, b_rd = 1'b0, b_we = 1'b0;
    logic [63:0] a_din = '0, b_din = '0;
    logic [7:0]  a_be = '0, b_be = '0;
    logic        a_busy, b_busy, a_dout_ready, b_dout_ready;
    logic [63:0] a_dout, b_dout;

    logic        DDRAM_CLK;
    logic        DDRAM_BUSY = 1'b0;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT = '0;
    logic        DDRAM_DOUT_READY = 1'b0;
    logic        DDRAM_RD, DDRAM_WE;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic wr_mon_en = 1'b0;
    int   wr_beats  = 0;
    int   grant_at;
    int   exp_grant_at;

    ddram_arbiter #(.MAX_WAIT(8)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .a_addr(a_addr), .a_burstcnt(a_burstcnt), .a_rd(a_rd), .a_we(a_we),
        .a_din(a_din), .a_be(a_be), .a_busy(a_busy), .a_dout(a_dout),
        .a_dout_ready(a_dout_ready),
        .b_addr(b_addr), .b_burstcnt(b_burstcnt), .b_rd(b_rd), .b_we(b_we),
        .b_din(b_din), .b_be(b_be), .b_busy(b_busy), .b_dout(b_dout),
        .b_dout_ready(b_dout_ready),
        .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(DDRAM_BUSY),
        .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
        .DDRAM_WE(DDRAM_WE), .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        a_rd = 0; a_we = 0; b_rd = 0; b_we = 0;
        a_addr = '0; b_addr = '0; a_burstcnt = '0; b_burstcnt = '0;
        a_din = '0; b_din = '0; a_be = '0; b_be = '0;
        DDRAM_BUSY = 0; DDRAM_DOUT_READY = 0; DDRAM_DOUT = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        clear_inputs();
        step();
        step();
        reset_n = 1;
    endtask

    // Scoreboard: every accepted write beat must match the next expected {be, din}.
    always @(negedge clk_sys) begin
        if (wr_mon_en && DDRAM_WE && !DDRAM_BUSY) begin
            if (exp_q.size() == 0) begin
                check("wr_extra_beat", {DDRAM_BE, DDRAM_DIN}, '0);
            end else begin
                check("wr_beat", {DDRAM_BE, DDRAM_DIN}, exp_q.pop_front());
                wr_beats++;
            end
        end
    end

    initial begin
        do_reset();
        settle();
        // Reset state
        check("rst_state", dbg_state, 0);
        check("rst_rd", DDRAM_RD, 0);
        check("rst_we", DDRAM_WE, 0);
        check("rst_addr", DDRAM_ADDR, 0);
        check("rst_a_busy", a_busy, 1);
        check("rst_b_busy", b_busy, 1);

        // 1) A read, burstcnt 4, addr 0x100
        a_rd = 1; a_addr = 29'h100; a_burstcnt = 8'd4;
        settle();
        check("t1_rd_before", DDRAM_RD, 0);
        step();
        settle();
        check("t1_rd_cmd", DDRAM_RD, 1);
        check("t1_addr", DDRAM_ADDR, 29'h100);
        check("t1_bc", DDRAM_BURSTCNT, 4);
        check("t1_a_busy", a_busy, 0);
        check("t1_b_busy", b_busy, 1);
        step();
        a_rd = 0;
        settle();
        check("t1_state_rd", dbg_state, 2);
        check("t1_rd_dropped", DDRAM_RD, 0);
        for (int i = 0; i < 5; i++) begin
            // gap cycle at i==2 with no strobe
            DDRAM_DOUT_READY = (i != 2);
            DDRAM_DOUT = 64'hA000 + 64'(i);
            settle();
            check("t1_a_rdy", a_dout_ready, (i != 2));
            check("t1_b_rdy", b_dout_ready, 0);
            check("t1_a_dout", a_dout, 64'hA000 + 64'(i));
            step();
        end
        DDRAM_DOUT_READY = 0;
        settle();
        check("t1_idle", dbg_state, 0);
        check("t1_a_busy_end", a_busy, 1);

        // 2) B write, burstcnt 3, DDRAM_BUSY high 2 cycles on beat 2
        wr_mon_en = 1; wr_beats = 0;
        exp_q.push_back({8'hFF, 64'h1111_0000_0000_0001});
        exp_q.push_back({8'h0F, 64'h2222_0000_0000_0002});
        exp_q.push_back({8'hF0, 64'h3333_0000_0000_0003});
        b_we = 1; b_addr = 29'h2A0; b_burstcnt = 8'd3;
        b_din = 64'h1111_0000_0000_0001; b_be = 8'hFF;
        step();
        settle();
        check("t2_we", DDRAM_WE, 1);
        check("t2_addr", DDRAM_ADDR, 29'h2A0);
        check("t2_bc", DDRAM_BURSTCNT, 3);
        check("t2_b_busy0", b_busy, 0);
        step();
        b_din = 64'h2222_0000_0000_0002; b_be = 8'h0F;
        b_addr = 29'h555; b_burstcnt = 8'd0;
        DDRAM_BUSY = 1;
        settle();
        check("t2_state_wr", dbg_state, 3);
        check("t2_b_busy_stall", b_busy, 1);
        check("t2_addr_held", DDRAM_ADDR, 29'h2A0);
        check("t2_bc_held", DDRAM_BURSTCNT, 3);
        step();
        settle();
        check("t2_b_busy_stall2", b_busy, 1);
        step();
        DDRAM_BUSY = 0;
        settle();
        check("t2_b_busy_go", b_busy, 0);
        check("t2_din1", DDRAM_DIN, 64'h2222_0000_0000_0002);
        step();
        b_din = 64'h3333_0000_0000_0003; b_be = 8'hF0;
        settle();
        check("t2_be2", DDRAM_BE, 8'hF0);
        check("t2_addr_held2", DDRAM_ADDR, 29'h2A0);
        step();
        b_we = 0;
        settle();
        check("t2_idle", dbg_state, 0);
        check("t2_we_off", DDRAM_WE, 0);
        check("t2_beats", wr_beats, 3);
        check("t2_q_empty", exp_q.size(), 0);
        wr_mon_en = 0;

        // 3) Simultaneous single-beat reads
        a_rd = 1; a_addr = 29'h10; a_burstcnt = 8'd1;
        b_rd = 1; b_addr = 29'h20; b_burstcnt = 8'd1;
        b_we = 0; b_din = '0; b_be = '0;
        step();
        settle();
        check("t3_a_cmd_addr", DDRAM_ADDR, 29'h10);
        check("t3_a_busy", a_busy, 0);
        check("t3_b_busy", b_busy, 1);
        step();
        a_rd = 0;
        DDRAM_DOUT_READY = 1;
        settle();
        check("t3_a_rdy", a_dout_ready, 1);
        check("t3_b_rdy_none", b_dout_ready, 0);
        step();
        DDRAM_DOUT_READY = 0;
        settle();
        check("t3_gap_rd", DDRAM_RD, 0);
        check("t3_gap_state", dbg_state, 0);
        step();
        settle();
        check("t3_b_cmd_rd", DDRAM_RD, 1);
        check("t3_b_cmd_addr", DDRAM_ADDR, 29'h20);
        check("t3_b_busy_go", b_busy, 0);
        step();
        b_rd = 0;
        DDRAM_DOUT_READY = 1;
        settle();
        check("t3_b_rdy", b_dout_ready, 1);
        check("t3_a_rdy_none", a_dout_ready, 0);
        step();
        DDRAM_DOUT_READY = 0;

        // 4) A requests continuously; B waits
`ifdef DDRAM_ARB_FAIRNESS_EN
        exp_grant_at = 10;
`else
        exp_grant_at = 0;
`endif
        grant_at = 0;
        a_rd = 1; a_addr = 29'h40; a_burstcnt = 8'd1;
        b_rd = 1; b_addr = 29'h80; b_burstcnt = 8'd1;
        DDRAM_DOUT_READY = 1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (grant_at == 0 && dbg_state == 2'd1 && !b_busy) grant_at = n;
        end
        check("t4_b_grant_cycle", grant_at, exp_grant_at);
        do_reset();

        // 5) Reset during RD_DATA after 2 of 8 beats
        a_rd = 1; a_addr = 29'h300; a_burstcnt = 8'd8;
        step();
        step();
        a_rd = 0;
        DDRAM_DOUT_READY = 1;
        step();
        step();
        reset_n = 0;
        settle();
        check("t5_rst_state", dbg_state, 0);
        check("t5_rst_a_busy", a_busy, 1);
        check("t5_rst_addr", DDRAM_ADDR, 0);
        check("t5_rst_a_rdy", a_dout_ready, 0);
        step();
        reset_n = 1;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("t5_stray_a", a_dout_ready, 0);
            check("t5_stray_b", b_dout_ready, 0);
            step();
        end
        DDRAM_DOUT_READY = 0;

        // 6) A write with burstcnt 0 is a single beat
        a_we = 1; a_addr = 29'h7; a_burstcnt = 8'd0; a_din = 64'hDEAD; a_be = 8'h01;
        step();
        settle();
        check("t6_we", DDRAM_WE, 1);
        check("t6_bc_zero", DDRAM_BURSTCNT, 0);
        check("t6_din", DDRAM_DIN, 64'hDEAD);
        step();
        a_we = 0;
        settle();
        check("t6_idle", dbg_state, 0);
        check("t6_a_busy", a_busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
